// File: rtl/imm_gen_pipe.sv
// RISC-V decode-stage immediate generator: extracts/extends I/S/B/U/J/zimm immediates
// and presents them through a registered valid/ready output with an optional skid entry.
module imm_gen_pipe #(
  parameter int MXLEN = 32,
  parameter int TAG_W = 5,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MXLEN-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [2:0] FMT_R = 3'b000;
  localparam logic [2:0] FMT_I = 3'b001;
  localparam logic [2:0] FMT_S = 3'b010;
  localparam logic [2:0] FMT_B = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [2:0] FMT_J = 3'b101;
  localparam logic [2:0] FMT_Z = 3'b110;

  // Every format fits in 32 bits, so build it there and sign-extend once to MXLEN.
  function automatic logic signed [MXLEN-1:0] f_imm(input logic [31:0] inst,
                                                    input logic [2:0]  fmt);
    logic signed [31:0] v;
    v = '0;
    case (fmt)
      FMT_R: v = '0;
      FMT_I: v = {{20{inst[31]}}, inst[31:20]};
      FMT_S: v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: v = {inst[31:12], 12'b0};
      FMT_J: v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_Z: v = {27'b0, inst[19:15]};
      default: v = '0;
    endcase
    return MXLEN'(v);
  endfunction

  function automatic logic f_err(input logic [2:0] fmt);
    return fmt == 3'b111;
  endfunction

  logic signed [MXLEN-1:0] w_imm_p0;
  logic                    w_err_p0;
  logic                    w_in_xfer_p0;
  logic                    w_load_out_p0;
  logic                    w_unused_opcode;

  logic                    r_vld_p1;
  logic [MXLEN-1:0]        r_imm_p1;
  logic [TAG_W-1:0]        r_tag_p1;
  logic                    r_err_p1;

  logic                    r_skid_vld_p1;
  logic [MXLEN-1:0]        r_skid_imm_p1;
  logic [TAG_W-1:0]        r_skid_tag_p1;
  logic                    r_skid_err_p1;

  assign w_unused_opcode = ^in_inst[6:0];

  // Stage p0: combinational extraction at the input
  assign w_imm_p0      = f_imm(in_inst, in_fmt);
  assign w_err_p0      = f_err(in_fmt);
  assign in_ready      = (SKID != 0) ? !r_skid_vld_p1 : (out_ready || !r_vld_p1);
  assign w_in_xfer_p0  = in_valid && in_ready;
  assign w_load_out_p0 = !r_vld_p1 || out_ready;

  // Stage p1: output register and skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (flush) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (w_load_out_p0) begin
      if (r_skid_vld_p1) begin
        r_vld_p1      <= 1'b1;
        r_skid_vld_p1 <= 1'b0;
      end else begin
        r_vld_p1 <= w_in_xfer_p0;
      end
    end else if (w_in_xfer_p0 && (SKID != 0)) begin
      r_skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm_p1 <= '0;
      r_tag_p1 <= '0;
      r_err_p1 <= 1'b0;
    end else if (w_load_out_p0) begin
      if (r_skid_vld_p1) begin
        r_imm_p1 <= r_skid_imm_p1;
        r_tag_p1 <= r_skid_tag_p1;
        r_err_p1 <= r_skid_err_p1;
      end else if (w_in_xfer_p0) begin
        r_imm_p1 <= w_imm_p0;
        r_tag_p1 <= in_tag;
        r_err_p1 <= w_err_p0;
      end
    end
  end

  // Skid payload only matters while r_skid_vld_p1 is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!w_load_out_p0 && w_in_xfer_p0) begin
      r_skid_imm_p1 <= w_imm_p0;
      r_skid_tag_p1 <= in_tag;
      r_skid_err_p1 <= w_err_p0;
    end
  end

  assign out_valid = r_vld_p1;
  assign out_imm   = r_imm_p1;
  assign out_tag   = r_tag_p1;
  assign out_err   = r_err_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe (MXLEN=64, SKID=1): directed cases plus randomized
// streaming with random backpressure and flushes, checked against a behavioural model.
module tb_imm_gen_pipe;
  localparam int MXLEN = 64;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_inst = '0;
  logic [2:0]       in_fmt = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [MXLEN-1:0] out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  imm_gen_pipe #(.MXLEN(MXLEN), .TAG_W(TAG_W), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_fmt(in_fmt),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   accepted;
  logic s_in_ready, s_out_valid;
  bit   rand_rdy = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sext(input longint v, input int w);
    if (((v >> (w - 1)) & 1) != 0) return v - (longint'(1) << w);
    return v;
  endfunction

  // Reference: gather the immediate's bits numerically, then sign-extend by subtraction.
  function automatic exp_t model(input logic [31:0] inst, input logic [2:0] fmt,
                                 input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint u;
    longint r;
    u = longint'({32'b0, inst});
    r = 0;
    e.err = 1'b0;
    case (fmt)
      3'd1: r = sext((u >> 20) & 'hFFF, 12);
      3'd2: r = sext((((u >> 25) & 'h7F) << 5) | ((u >> 7) & 31), 12);
      3'd3: r = sext((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                     (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      3'd4: r = sext(u & 'hFFFFF000, 32);
      3'd5: r = sext((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                     (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
      3'd6: r = (u >> 15) & 31;
      3'd7: e.err = 1'b1;
      default: r = 0;
    endcase
    e.imm = r;
    e.tag = tag;
    return e;
  endfunction

  // One cycle: inputs already set at posedge+1; acceptance is judged at the negedge.
  task automatic step();
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    accepted    = in_valid && in_ready && !flush && rst_n;
    if (accepted) sb.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [2:0] fmt,
                      input logic [TAG_W-1:0] tag, input logic [63:0] eimm, input logic eerr);
    in_inst  = inst;
    in_fmt   = fmt;
    in_tag   = tag;
    cur.imm  = eimm;
    cur.tag  = tag;
    cur.err  = eerr;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (accepted) break;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: inst 0x%08h never accepted within 100 cycles", inst);
    end
  endtask

  task automatic send_rand();
    logic [31:0]      inst;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
    exp_t             m;
    inst = $urandom;
    fmt  = 3'($urandom_range(0, 7));
    tag  = TAG_W'($urandom);
    m    = model(inst, fmt, tag);
    send(inst, fmt, tag, m.imm, m.err);
  endtask

  // Monitor: pops and compares on each output transfer, and checks stall stability.
  bit               st_pend = 0;
  logic [63:0]      st_imm;
  logic [TAG_W-1:0] st_tag;
  logic             st_err;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      st_pend = 0;
    end else begin
      if (st_pend)
        chk("stall_hold", {out_valid, out_imm, out_tag, out_err},
            {1'b1, st_imm, st_tag, st_err});
      st_pend = out_valid && !out_ready && !flush;
      st_imm  = out_imm;
      st_tag  = out_tag;
      st_err  = out_err;
      if (flush) begin
        sb.delete();
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: imm=0x%0h tag=%0d while nothing expected",
                   out_imm, out_tag);
        end else begin
          e = sb.pop_front();
          chk("out_imm", out_imm, e.imm);
          chk("out_tag", out_tag, e.tag);
          chk("out_err", out_err, e.err);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_err", out_err, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed extraction cases
    out_ready = 1'b1;
    send(32'hFFF00093, 3'd1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("latency1_valid", out_valid, 1);
    send(32'hFE000EE3, 3'd3, 5'd4, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(32'h0010006F, 3'd5, 5'd5, 64'h0000_0000_0000_0800, 1'b0);
    send(32'hFE112E23, 3'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(32'h80000037, 3'd4, 5'd7, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send(32'h12345037, 3'd4, 5'd8, 64'h0000_0000_1234_5000, 1'b0);
    send(32'h000FD073, 3'd6, 5'd9, 64'h0000_0000_0000_001F, 1'b0);
    send(32'hFFFFFFB3, 3'd0, 5'd10, 64'h0, 1'b0);
    step();
    step();

    // Backpressure: A in output, B in skid, C held by source
    out_ready = 1'b0;
    send(32'h00100093, 3'd1, 5'd11, 64'h1, 1'b0);
    send(32'h80000037, 3'd4, 5'd12, 64'hFFFF_FFFF_8000_0000, 1'b0);
    in_inst = 32'h000FD073; in_fmt = 3'd6; in_tag = 5'd13;
    cur.imm = 64'h1F; cur.tag = 5'd13; cur.err = 1'b0;
    in_valid = 1'b1;
    step();
    chk("bp_in_ready_low", s_in_ready, 0);
    chk("bp_out_valid", s_out_valid, 1);
    step();
    chk("bp_in_ready_still_low", s_in_ready, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_stream_valid", s_out_valid, 1);
      if (accepted) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    step();
    chk("bp_drained_valid", s_out_valid, 0);
    chk("bp_sb_empty", sb.size(), 0);

    // Flush with two items pending and a simultaneous input
    out_ready = 1'b0;
    send(32'h00500093, 3'd1, 5'd14, 64'h5, 1'b0);
    send(32'h00600093, 3'd1, 5'd15, 64'h6, 1'b0);
    in_inst = 32'h00700093; in_fmt = 3'd1; in_tag = 5'd16;
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("flush_out_valid", s_out_valid, 0);
    chk("flush_in_ready", s_in_ready, 1);
    out_ready = 1'b1;
    repeat (3) step();
    chk("flush_nothing_out", s_out_valid, 0);
    send(32'hDEADBEEF, 3'd7, 5'd17, 64'h0, 1'b1);
    step();

    // Reset asserted mid-stall
    out_ready = 1'b0;
    send(32'h7FF00093, 3'd1, 5'd18, 64'h7FF, 1'b0);
    chk("stall_pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_imm", out_imm, 0);
    chk("async_rst_tag", out_tag, 0);
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    send(32'h80000093, 3'd1, 5'd21, 64'hFFFF_FFFF_FFFF_F800, 1'b0);
    chk("post_rst_latency1", out_valid, 1);
    step();

    // Randomized streaming with random backpressure and occasional flushes
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      if ($urandom_range(0, 49) == 0) begin
        flush = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        step();
        flush = 1'b0;
        in_valid = 1'b0;
      end
      send_rand();
    end
    rand_rdy = 0;
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      step();
    end
    step();
    chk("drain_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined RISC-V immediate generator for the decode stage, parametrised in XLEN.
- Extracts and extends the immediate for formats R/I/S/B/U/J plus CSR zimm.
- Registered output with a valid/ready handshake and a one-entry skid buffer, so full-throughput streaming survives downstream stalls.
- Sits between the instruction fetch buffer and the register-read/ALU operand mux; a sideband tag travels with each instruction.

Parameters:
- MXLEN, 32, datapath width. Legal values are 32 and 64; the immediate is extended to MXLEN.
- TAG_W, 5, width of the sideband tag carried alongside each immediate.
- SKID, 1, selects the buffering mode. 1 = one-entry skid buffer (in_ready registered). 0 = single pipeline register (in_ready = out_ready | !out_valid).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_inst  in  32  raw instruction word.
- in_fmt  in  3  format select: 000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110 Z (CSR zimm), 111 illegal.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output immediate valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_imm  out  MXLEN  extended immediate.
- out_tag  out  TAG_W  tag associated with out_imm.
- out_err  out  1  in_fmt was 111.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_imm=0, out_tag=0, out_err=0, skid empty.
  - in_ready reads 1 once rst_n is high; inputs are ignored while rst_n is low.
- Immediate rules, where s = inst[31] replicated up to MXLEN:
  - R: all zeros.
  - I: {s, inst[30:20]}.
  - S: {s, inst[30:25], inst[11:7]}.
  - B: {s, inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {s, inst[30:12], 12'b0}; sign-extends above bit 31 when MXLEN=64.
  - J: {s, inst[19:12], inst[20], inst[30:21], 1'b0}.
  - Z: zero-extended inst[19:15].
  - Illegal: imm=0 and err=1. For every other format err=0.
- Latency: the immediate is computed combinationally at the input and captured in the output register. An item accepted in cycle N is visible at cycle N+1.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- SKID=1:
  - in_ready = !skid_valid (registered, with no combinational path from out_ready).
  - Accepted item goes to the output register if it is empty or being drained this cycle; otherwise it goes to the skid register.
  - On an output transfer with skid_valid, the skid contents move to the output register and the skid clears. A simultaneous input transfer cannot occur, because in_ready is 0.
  - Order is always preserved; no item is lost or duplicated.
- SKID=0: a single register; in_ready = out_ready | !out_valid (combinational).
- Stall stability: while out_valid & !out_ready, out_imm, out_tag and out_err are held stable.
- Flush:
  - Next cycle, out_valid=0 and the skid is empty.
  - A simultaneous input transfer is dropped; flush has priority.
  - Data registers may keep stale values, but out_valid is 0.
- Back-to-back streaming with out_ready held at 1 sustains one item per cycle.
- Reset asserted mid-stall: all pending items are discarded immediately and the reset values apply.

Test Plan:
- MXLEN=32, fmt I, inst 0xFFF00093, tag 3 -> next cycle out_imm=0xFFFFFFFF, tag=3, err=0.
- Extraction cases:
  - fmt B, inst 0xFE000EE3 -> out_imm=0xFFFFFFFC.
  - fmt J, inst 0x0010006F -> 0x00000800.
  - fmt S, inst 0xFE112E23 -> 0xFFFFFFFC.
- MXLEN=64:
  - fmt U, inst 0x80000037 -> 0xFFFFFFFF80000000.
  - fmt U, inst 0x12345037 -> 0x0000000012345000.
  - fmt Z, inst 0x000FD073 -> 0x1F.
- SKID=1 backpressure:
  - Hold out_ready=0 and push items A, B, C.
  - A sits in the output register, B in the skid, in_ready=0, C is held by the source.
  - Raise out_ready -> A, B, C emerge in order on consecutive cycles with no gaps or duplicates.
- Flush and illegal format:
  - With A and B pending plus flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted.
  - Then fmt 111 -> out_err=1, out_imm=0.
- Reset mid-stall: pull rst_n low while out_valid=1 -> out_valid=0 asynchronously; after release, a fresh I-type item passes with latency 1.
